// File: rtl/wallace_final_cpa_pkg.sv
// Shared definitions for the Wallace-tree multiplier path.
// Holds default vector widths, the CPA state encoding and the chunk count helper.
package wallace_pkg;

  localparam int WAL_SUM_W     = 28;
  localparam int WAL_CARRY_W   = 25;
  localparam int WAL_CARRY_OFS = 3;
  localparam int WAL_CHUNK_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_HOLD = 2'd2
  } cpa_state_t;

  function automatic int num_chunks(input int width, input int chunk_w);
    return (width + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/wallace_final_cpa_if.sv
// Handshake bundle between the last 3:2 compression stage, the final CPA
// and the multiplier result register.
interface wallace_final_cpa_if
  import wallace_pkg::*;
#(
  parameter int SUM_W   = WAL_SUM_W,
  parameter int CARRY_W = WAL_CARRY_W
);
  logic               in_valid;
  logic               in_ready;
  logic [SUM_W-1:0]   sum_in;
  logic [CARRY_W-1:0] carry_in;
  logic               out_valid;
  logic               out_ready;
  logic [SUM_W-1:0]   res;
  logic               res_cout;

  modport master (
    output in_valid, sum_in, carry_in, out_ready,
    input  in_ready, out_valid, res, res_cout
  );

  modport slave (
    input  in_valid, sum_in, carry_in, out_ready,
    output in_ready, out_valid, res, res_cout
  );
endinterface

// File: rtl/wallace_final_cpa_chunk_adder.sv
// One CHUNK_W-bit slice of the carry-propagate adder; purely combinational.
module cpa_chunk_adder #(
  parameter int W = 7
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
endmodule

// File: rtl/wallace_final_cpa.sv
// Final carry-propagate adder of the Wallace tree: folds the redundant
// sum/carry pair into a binary result, CHUNK_W bits per cycle.
module wallace_final_cpa
  import wallace_pkg::*;
#(
  parameter int SUM_W     = WAL_SUM_W,
  parameter int CARRY_W   = WAL_CARRY_W,
  parameter int CARRY_OFS = WAL_CARRY_OFS,
  parameter int CHUNK_W   = WAL_CHUNK_W
) (
  input logic               clk,
  input logic               rst,
  wallace_final_cpa_if.slave bus
);
  localparam int NUM_CHUNKS = num_chunks(SUM_W, CHUNK_W);
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
  localparam int TOP_W      = SUM_W - (NUM_CHUNKS - 1) * CHUNK_W;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  cpa_state_t                          state_q;
  logic [CNT_W-1:0]                    cnt_q;
  logic                                carry_q;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  a_q, b_q, res_q;
  logic [PAD_W-1:0]                    res_flat;
  logic                                in_ready_q, out_valid_q, res_cout_q;

  logic [SUM_W-1:0]   b_align;
  logic [CHUNK_W-1:0] ch_sum;
  logic               ch_cout;
  logic [CHUNK_W:0]   ch_full;
  logic               last_chunk;

  // Carry bits above SUM_W are simply shifted out of the SUM_W-wide vector.
  assign b_align    = SUM_W'(bus.carry_in) << CARRY_OFS;
  assign ch_full    = {ch_cout, ch_sum};
  assign last_chunk = (cnt_q == CNT_W'(NUM_CHUNKS - 1));

  cpa_chunk_adder #(.W(CHUNK_W)) u_chunk (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= PAD_W'(bus.sum_in);
            b_q        <= PAD_W'(b_align);
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_ADD;
          end
        end
        ST_ADD: begin
          res_q[cnt_q] <= ch_sum;
          carry_q      <= ch_cout;
          cnt_q        <= cnt_q + 1'b1;
          if (last_chunk) begin
            // A narrow top chunk sums zero-padded operands, so bit SUM_W
            // lands inside the chunk result rather than on its carry-out.
            res_cout_q  <= ch_full[TOP_W];
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_flat      = res_q;
  assign bus.res       = res_flat[SUM_W-1:0];
  assign bus.res_cout  = res_cout_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_wallace_final_cpa.sv
// Self-checking bench for wallace_final_cpa: directed vectors, handshake
// corner cases and a randomised run checked through an expected-result queue.
module tb_wallace_final_cpa;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wallace_final_cpa_if #(.SUM_W(28), .CARRY_W(25)) bus ();

  wallace_final_cpa dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [27:0] r;
    logic        c;
  } exp_t;

  typedef struct {
    logic [27:0] s;
    logic [24:0] c;
    logic [27:0] r;
    logic        co;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;
  int   n_res = 0;
  bit   rnd_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [27:0] s, input logic [24:0] c);
    logic [28:0] full;
    exp_t e;
    full = 29'(s) + (29'(c) << 3);
    e.r  = full[27:0];
    e.c  = full[28];
    return e;
  endfunction

  // Result monitor: a handshake is committed at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_res++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got res=%h with nothing outstanding", bus.res);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res", 32'(bus.res), 32'(e.r));
        chk("res_cout", 32'(bus.res_cout), 32'(e.c));
      end
    end
  end

  task automatic send(input logic [27:0] s, input logic [24:0] c, input exp_t e);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.sum_in   = s;
    bus.carry_in = c;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        exp_q.push_back(e);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready never rose, expected 1");
    end
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    exp_t e;
    logic [27:0] r0;

    vecs[0] = '{28'h0000001, 25'h0000000, 28'h0000001, 1'b0};
    vecs[1] = '{28'h000007F, 25'h0000001, 28'h0000087, 1'b0};
    vecs[2] = '{28'hFFFFFFF, 25'h0000001, 28'h0000007, 1'b1};
    vecs[3] = '{28'h0000000, 25'h1FFFFFF, 28'hFFFFFF8, 1'b0};
    vecs[4] = '{28'hFFFFFFF, 25'h1FFFFFF, 28'hFFFFFF7, 1'b1};
    vecs[5] = '{28'h0AAAAAA, 25'h1555555, 28'hB555552, 1'b0};

    bus.in_valid  = 1'b0;
    bus.sum_in    = '0;
    bus.carry_in  = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_res", 32'(bus.res), 32'd0);
    chk("reset_res_cout", 32'(bus.res_cout), 32'd0);

    // Directed vectors with latency check.
    for (int v = 0; v < 6; v++) begin
      e.r = vecs[v].r;
      e.c = vecs[v].co;
      send(vecs[v].s, vecs[v].c, e);
      wait_out_valid(lat);
      chk("latency", 32'(lat), 32'd5);
    end

    // Backpressure: result must hold steady while out_ready is low.
    @(posedge clk); #1 bus.out_ready = 1'b0;
    send(28'h0F0F0F0, 25'h0ABCDEF, model(28'h0F0F0F0, 25'h0ABCDEF));
    wait_out_valid(lat);
    chk("bp_latency", 32'(lat), 32'd5);
    r0 = bus.res;
    chk("bp_res_value", 32'(r0), 32'(model(28'h0F0F0F0, 25'h0ABCDEF).r));
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_res_stable", 32'(bus.res), 32'(r0));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the second ADD cycle aborts the operation.
    send(28'h5555555, 25'h0AAAAAA, model(28'h5555555, 25'h0AAAAAA));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_res", 32'(bus.res), 32'd0);
    chk("abort_res_cout", 32'(bus.res_cout), 32'd0);
    e.r = 28'h12345E7;
    e.c = 1'b0;
    send(28'h1234567, 25'h0000010, e);
    wait_out_valid(lat);
    chk("post_abort_latency", 32'(lat), 32'd5);
    @(negedge clk);

    // Randomised traffic with random stalls on both sides.
    begin
      int base;
      base = n_res;
      fork
        begin
          for (int n = 0; n < 1000; n++) begin
            logic [27:0] s;
            logic [24:0] c;
            s = 28'($urandom);
            c = 25'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(s, c, model(s, c));
          end
          for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
          rnd_done = 1;
        end
        begin
          while (!rnd_done) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
          end
          bus.out_ready = 1'b1;
        end
      join
      chk("random_result_count", 32'(n_res - base), 32'd1000);
      chk("random_queue_drained", 32'(exp_q.size()), 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wallace_final_cpa.md
Name: wallace_final_cpa

Overview:
- Consumer end of the Wallace-tree compression interface. Takes the final redundant sum/carry vector pair from the last 3:2 compression stage and resolves it into one binary product with a multi-cycle, chunked carry-propagate adder.
- Sits between the partial-product tree and the multiplier result register.
- Uses a valid/ready handshake on both sides, so the tree can be stalled.
- Carry is resolved CHUNK_W bits per cycle, which keeps the critical path short.

Parameters:
- SUM_W, 28, width of the sum vector and of the result.
- CARRY_W, 25, width of the carry vector; the tree has already dropped its top carry bit.
- CARRY_OFS, 3, column weight of carry bit 0. Carry bit m has weight m+CARRY_OFS. Must satisfy CARRY_W+CARRY_OFS <= SUM_W.
- CHUNK_W, 7, bits resolved per ADD cycle.
- NUM_CHUNKS, ceil(SUM_W/CHUNK_W) = 4, derived localparam; not overridable.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sum_in/carry_in are valid.
- in_ready  out  1  block can accept an operand pair.
- sum_in  in  SUM_W  sum vector from the compression stage.
- carry_in  in  CARRY_W  carry vector, weights as given by CARRY_OFS.
- out_valid  out  1  res/res_cout are valid.
- out_ready  in  1  downstream accepts the result.
- res  out  SUM_W  (sum_in + (carry_in << CARRY_OFS)) mod 2^SUM_W.
- res_cout  out  1  bit SUM_W of the full sum; for checking only.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, res=0, res_cout=0, chunk counter=0, internal carry=0. Reset wins over every other event in the same cycle.
- Operand alignment: carry_in is zero-extended to SUM_W after the left shift by CARRY_OFS. Bits above SUM_W are discarded. Sum and shifted carry are captured into internal registers A and B.
- Top chunk: the last chunk may be narrower than CHUNK_W (SUM_W - (NUM_CHUNKS-1)*CHUNK_W bits).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: capture A, B; clear carry and counter; go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle, chunk k = counter is computed as {c, r} = A[k] + B[k] + carry.
  - r is written into res chunk k; carry <= c; counter increments.
  - After the cycle where counter = NUM_CHUNKS-1: res_cout <= final carry; go to HOLD.
- HOLD:
  - out_valid=1; res and res_cout are stable.
  - On out_ready: go to IDLE and drop out_valid the next cycle.
  - With out_ready low, HOLD is kept indefinitely and res must not change.
- Latency: handshake in cycle T, then ADD in T+1 .. T+NUM_CHUNKS, with out_valid first high in cycle T+NUM_CHUNKS+1.
- Throughput: at most one operation per NUM_CHUNKS+2 cycles. in_ready is 0 throughout ADD and HOLD, and in_valid is ignored there.
- res is partially updated while in ADD. Downstream samples only when out_valid=1.
- Reset during ADD or HOLD: abort the operation, outputs return to reset values, and no out_valid pulse is emitted.
- Width rule: the chunk adder is CHUNK_W+1 bits wide, and the result wraps modulo 2^SUM_W.

Decomposition:
- Shared package wallace_pkg holds:
  - the state enum (IDLE, ADD, HOLD);
  - default widths SUM_W/CARRY_W/CARRY_OFS, shared with the compression stages;
  - the function computing NUM_CHUNKS.
- One sub-module: cpa_chunk_adder, purely combinational. Inputs are CHUNK_W-bit a and b plus cin; outputs are sum and cout.
- The FSM, counter, and operand/result registers live in the top module.

Test Plan:
- Reset, then sum_in=28'h0000001, carry_in=0 -> out_valid rises 5 cycles after accept; res=28'h0000001, res_cout=0.
- Chunk-boundary carry: sum_in=28'h000007F, carry_in=25'h0000001 (weight 8) -> res=28'h0000087, res_cout=0.
- Full ripple and wrap: sum_in=28'hFFFFFFF, carry_in=25'h0000001 -> res=28'h0000007, res_cout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> out_valid and res stay constant and in_ready stays 0. Raising out_ready gives one handshake, then in_ready=1 the next cycle.
- Reset mid-ADD: assert rst in the second ADD cycle -> next cycle in_ready=1, out_valid=0, res=0. A following operation (sum_in=28'h1234567, carry_in=25'h0000010) yields res=28'h12345E7.
- Randomised back-to-back: 1000 random pairs with random in_valid/out_ready -> each res matches the reference model (sum + carry<<3) mod 2^28, with no lost or duplicated results.
